pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It drives the load, bubble and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It tracks outstanding I-cache and D-cache responses with sticky completion flags, so the pipeline advances only when both memory ports are satisfied. It also inserts load-use bubbles and squashes wrong-path instructions on taken branches and jumps.

---
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage pipeline.
// Sticky completion flags let the pipeline advance only once both the I-cache
// and D-cache ports have responded. The controller also inserts load-use
// bubbles and squashes wrong-path instructions on taken branches.
// Optional performance counters are enabled with `define PIPELINE_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_resp,
    input  logic                  dmem_resp,
    input  logic                  mem_access,
    input  logic                  ex_br_taken,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  if_id_uses_rs1,
    input  logic                  if_id_uses_rs2,
    output logic                  imem_read,
    output logic                  dmem_req_en,
    output logic                  load_pc,
    output logic                  load_if_id,
    output logic                  load_id_ex,
    output logic                  load_ex_mem,
    output logic                  load_mem_wb,
    output logic                  bubble_id_ex,
    output logic                  flush_if_id,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] bubble_count,
    output logic [PERF_CNT_W-1:0] flush_count
);

    logic i_done;
    logic d_done;
    logic i_ok;
    logic d_ok;
    logic advance;
    logic go;
    logic hazard;
    logic take_br;
    logic take_hz;

    assign i_ok    = i_done | imem_resp;
    assign d_ok    = ~mem_access | d_done | dmem_resp;
    assign advance = i_ok & d_ok;
    // Reset suppresses every load pulse even if both ports look satisfied.
    assign go      = advance & ~rst;

    assign hazard = id_ex_mem_read & (id_ex_rd != '0) &
                    ((if_id_uses_rs1 & (id_ex_rd == if_id_rs1)) |
                     (if_id_uses_rs2 & (id_ex_rd == if_id_rs2)));

    // Branch outranks the hazard: the hazarding instruction is wrong-path.
    assign take_br = go & ex_br_taken;
    assign take_hz = go & ~ex_br_taken & hazard;

    assign imem_read   = ~i_done & ~rst;
    assign dmem_req_en = mem_access & ~d_done & ~rst;

    // Stage-register load, bubble and flush controls.
    always_comb begin
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        if (go) begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (take_br) begin
                bubble_id_ex = 1'b1;
                flush_if_id  = 1'b1;
            end else if (take_hz) begin
                load_pc      = 1'b0;
                load_if_id   = 1'b0;
                bubble_id_ex = 1'b1;
            end
        end
    end

    // Sticky response flags; on a load-use bubble the fetched instruction
    // is held, so i_done stays set and the I-port is not re-requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else if (advance) begin
            i_done <= take_hz;
            d_done <= 1'b0;
        end else begin
            i_done <= i_done | imem_resp;
            d_done <= d_done | (dmem_resp & mem_access);
        end
    end

`ifdef PIPELINE_PERF_CNT_EN
    // Wrapping performance counters for stalls, bubbles and flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (!advance) stall_cycles <= stall_cycles + 1'b1;
            if (take_hz)  bubble_count <= bubble_count + 1'b1;
            if (take_br)  flush_count  <= flush_count + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
    assign bubble_count = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a reference model pushes the
// expected outputs into a queue as each cycle's stimulus is driven; each test
// task pops and compares once the DUT outputs have settled.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_resp, dmem_resp, mem_access, ex_br_taken, id_ex_mem_read;
    logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
    logic       if_id_uses_rs1, if_id_uses_rs2;
    logic       imem_read, dmem_req_en, load_pc, load_if_id, load_id_ex;
    logic       load_ex_mem, load_mem_wb, bubble_id_ex, flush_if_id;
    logic [31:0] stall_cycles, bubble_count, flush_count;
    logic [8:0] obs_ctl;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .PERF_CNT_W(32)) dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
        .mem_access(mem_access), .ex_br_taken(ex_br_taken),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
        .imem_read(imem_read), .dmem_req_en(dmem_req_en), .load_pc(load_pc),
        .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count),
        .flush_count(flush_count)
    );

    assign obs_ctl = {imem_read, dmem_req_en, load_pc, load_if_id, load_id_ex,
                      load_ex_mem, load_mem_wb, bubble_id_ex, flush_if_id};

    typedef struct packed {
        logic       rst, ir, dr, ma, br, mr;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2;
    } row_t;

    typedef struct {
        logic [8:0]  ctl;
        logic [31:0] sc, bc, fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic        m_i = 1'b0, m_d = 1'b0;
    logic [31:0] m_sc = '0, m_bc = '0, m_fc = '0;

    function automatic row_t mk(input logic r, ir, dr, ma, br, mr,
                                input logic [4:0] rd, rs1, rs2,
                                input logic u1, u2);
        row_t x;
        x.rst = r; x.ir = ir; x.dr = dr; x.ma = ma; x.br = br; x.mr = mr;
        x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2;
        return x;
    endfunction

    // Apply one cycle of stimulus, push the model's expectation, wait to negedge.
    task automatic drive(input row_t r);
        exp_t e;
        logic iok, dok, adv, hz;
        @(posedge clk); #1;
        rst = r.rst; imem_resp = r.ir; dmem_resp = r.dr; mem_access = r.ma;
        ex_br_taken = r.br; id_ex_mem_read = r.mr; id_ex_rd = r.rd;
        if_id_rs1 = r.rs1; if_id_rs2 = r.rs2;
        if_id_uses_rs1 = r.u1; if_id_uses_rs2 = r.u2;

        iok = m_i | r.ir;
        dok = !r.ma | m_d | r.dr;
        adv = iok & dok & !r.rst;
        hz  = r.mr && (r.rd != 5'd0) &&
              ((r.u1 && r.rd == r.rs1) || (r.u2 && r.rd == r.rs2));
        e.ctl = {!m_i && !r.rst, r.ma && !m_d && !r.rst, 7'b0000000};
        if (adv) begin
            if (r.br)    e.ctl[6:0] = 7'b1111111;
            else if (hz) e.ctl[6:0] = 7'b0011110;
            else         e.ctl[6:0] = 7'b1111100;
        end
`ifdef PIPELINE_PERF_CNT_EN
        e.sc = m_sc; e.bc = m_bc; e.fc = m_fc;
`else
        e.sc = '0; e.bc = '0; e.fc = '0;
`endif
        sb.push_back(e);

        if (r.rst) begin
            m_i = 1'b0; m_d = 1'b0; m_sc = '0; m_bc = '0; m_fc = '0;
        end else if (iok && dok) begin
            m_i = hz && !r.br;
            m_d = 1'b0;
            if (r.br)      m_fc = m_fc + 1;
            else if (hz)   m_bc = m_bc + 1;
        end else begin
            m_i  = m_i | r.ir;
            m_d  = m_d | (r.dr & r.ma);
            m_sc = m_sc + 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        row_t rows[3];
        exp_t e;
        rows[0] = mk(1,1,0,0,0,0, 0,0,0, 0,0);
        rows[1] = mk(1,1,0,0,0,0, 0,0,0, 0,0);
        rows[2] = mk(0,0,0,0,0,0, 0,0,0, 0,0);
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL reset[%0d] ctl got %b want %b", i, obs_ctl, e.ctl);
            end
            n_checks++;
            if ({stall_cycles, bubble_count, flush_count} !== {e.sc, e.bc, e.fc}) begin
                n_fail++;
                $display("FAIL reset[%0d] cnt got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         stall_cycles, bubble_count, flush_count, e.sc, e.bc, e.fc);
            end
        end
    endtask

    task automatic test_imiss();
        row_t rows[5];
        exp_t e;
        rows[0] = mk(1,0,0,0,0,0, 0,0,0, 0,0);
        for (int i = 1; i < 4; i++) rows[i] = mk(0,0,0,0,0,0, 0,0,0, 0,0);
        rows[4] = mk(0,1,0,0,0,0, 0,0,0, 0,0);
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL imiss[%0d] ctl got %b want %b", i, obs_ctl, e.ctl);
            end
            n_checks++;
            if (stall_cycles !== e.sc) begin
                n_fail++;
                $display("FAIL imiss[%0d] stall got %0d want %0d", i, stall_cycles, e.sc);
            end
        end
    endtask

    task automatic test_split();
        row_t rows[6];
        exp_t e;
        rows[0] = mk(0,0,1,1,0,0, 0,0,0, 0,0);
        rows[1] = mk(0,0,0,1,0,0, 0,0,0, 0,0);
        rows[2] = mk(0,0,1,1,0,0, 0,0,0, 0,0);
        rows[3] = mk(0,1,0,1,0,0, 0,0,0, 0,0);
        rows[4] = mk(0,0,0,1,0,0, 0,0,0, 0,0);
        rows[5] = mk(0,1,1,1,0,0, 0,0,0, 0,0);
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL split[%0d] ctl got %b want %b", i, obs_ctl, e.ctl);
            end
        end
    endtask

    task automatic test_load_use();
        row_t rows[3];
        exp_t e;
        rows[0] = mk(0,1,0,0,0,1, 5,3,5, 0,1);
        rows[1] = mk(0,0,0,0,0,0, 5,3,5, 0,1);
        rows[2] = mk(0,1,0,0,0,1, 7,7,2, 1,0);
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL load_use[%0d] ctl got %b want %b", i, obs_ctl, e.ctl);
            end
            n_checks++;
            if (bubble_count !== e.bc) begin
                n_fail++;
                $display("FAIL load_use[%0d] bubbles got %0d want %0d", i, bubble_count, e.bc);
            end
        end
    endtask

    task automatic test_branch_hazard();
        row_t rows[3];
        exp_t e;
        rows[0] = mk(0,1,0,0,1,1, 9,9,0, 1,0);
        rows[1] = mk(0,1,0,1,0,0, 0,0,0, 0,0);
        rows[2] = mk(0,1,1,1,0,0, 0,0,0, 0,0);
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL br_hz[%0d] ctl got %b want %b", i, obs_ctl, e.ctl);
            end
            n_checks++;
            if ({bubble_count, flush_count} !== {e.bc, e.fc}) begin
                n_fail++;
                $display("FAIL br_hz[%0d] cnt got %0d/%0d want %0d/%0d", i,
                         bubble_count, flush_count, e.bc, e.fc);
            end
        end
    endtask

    task automatic test_x0_load();
        row_t rows[2];
        exp_t e;
        rows[0] = mk(0,1,0,0,0,1, 0,0,0, 1,0);
        rows[1] = mk(0,1,0,0,0,1, 0,4,0, 1,1);
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL x0_load[%0d] ctl got %b want %b", i, obs_ctl, e.ctl);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        row_t rows[4];
        exp_t e;
        rows[0] = mk(0,0,1,1,0,0, 0,0,0, 0,0);
        rows[1] = mk(1,1,1,1,0,0, 0,0,0, 0,0);
        rows[2] = mk(0,0,0,1,0,0, 0,0,0, 0,0);
        rows[3] = mk(0,1,1,1,0,0, 0,0,0, 0,0);
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL rst_stall[%0d] ctl got %b want %b", i, obs_ctl, e.ctl);
            end
            n_checks++;
            if (stall_cycles !== e.sc) begin
                n_fail++;
                $display("FAIL rst_stall[%0d] stall got %0d want %0d", i, stall_cycles, e.sc);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t r;
        exp_t e;
        for (int i = 0; i < 80; i++) begin
            r = mk(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 1),
                   $urandom_range(0, 1));
            drive(r);
            e = sb.pop_front();
            n_checks++;
            if (obs_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL b2b[%0d] ctl got %b want %b", i, obs_ctl, e.ctl);
            end
            n_checks++;
            if ({stall_cycles, bubble_count, flush_count} !== {e.sc, e.bc, e.fc}) begin
                n_fail++;
                $display("FAIL b2b[%0d] cnt got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         stall_cycles, bubble_count, flush_count, e.sc, e.bc, e.fc);
            end
        end
    endtask

    initial begin
        rst = 1'b1; imem_resp = 1'b0; dmem_resp = 1'b0; mem_access = 1'b0;
        ex_br_taken = 1'b0; id_ex_mem_read = 1'b0; id_ex_rd = '0;
        if_id_rs1 = '0; if_id_rs2 = '0; if_id_uses_rs1 = 1'b0; if_id_uses_rs2 = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_imiss();
        test_split();
        test_load_use();
        test_branch_hazard();
        test_x0_load();
        test_reset_mid_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
